// File: rtl/armleocpu_rf_read_arbiter_if.sv
// Signal bundle between decode, the debug module, register file ports 1/2 and the
// rs1 read arbiter. The arbiter takes the slave view; its surroundings take the master view.
interface armleocpu_rf_read_arbiter_if;
  logic        d_rs1_read;
  logic [4:0]  d_rs1_raddr;
  logic        d_rs2_read;
  logic [4:0]  d_rs2_raddr;
  logic        d_stall;

  logic        rf_rs1_read;
  logic [4:0]  rf_rs1_raddr;
  logic        rf_rs2_read;
  logic [4:0]  rf_rs2_raddr;
  logic [31:0] rf_rs1_rdata;

  logic        dbg_rf_req;
  logic [4:0]  dbg_rf_addr;
  logic        dbg_rf_ack;
  logic        dbg_rf_rvalid;
  logic [31:0] dbg_rf_rdata;
  logic        dbg_rf_busy;

  modport slave (
    input  d_rs1_read, d_rs1_raddr, d_rs2_read, d_rs2_raddr,
    input  rf_rs1_rdata, dbg_rf_req, dbg_rf_addr,
    output d_stall, rf_rs1_read, rf_rs1_raddr, rf_rs2_read, rf_rs2_raddr,
    output dbg_rf_ack, dbg_rf_rvalid, dbg_rf_rdata, dbg_rf_busy
  );

  modport master (
    output d_rs1_read, d_rs1_raddr, d_rs2_read, d_rs2_raddr,
    output rf_rs1_rdata, dbg_rf_req, dbg_rf_addr,
    input  d_stall, rf_rs1_read, rf_rs1_raddr, rf_rs2_read, rf_rs2_raddr,
    input  dbg_rf_ack, dbg_rf_rvalid, dbg_rf_rdata, dbg_rf_busy
  );
endinterface

// File: rtl/armleocpu_rf_read_arbiter.sv
// Shares register-file read port 1 between decode (priority) and the debug module,
// with a starvation counter that forces a debug slot by stalling decode for one cycle.
module armleocpu_rf_read_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input logic                           clk,
  input logic                           rst_n,
  armleocpu_rf_read_arbiter_if.slave    bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  starve_cnt;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic port_free;
  logic force_slot;
  logic arb_phase;
  logic grant;

  // Grant is suppressed while reset is held so outputs fall back to pure decode passthrough.
  always_comb begin
    port_free  = !bus.d_rs1_read;
    force_slot = (starve_cnt == LIMIT);
    arb_phase  = rst_n && ((state == IDLE) || (state == WAIT));
    grant      = arb_phase && bus.dbg_rf_req && (port_free || force_slot);
  end

  always_comb begin
    bus.rf_rs2_read   = bus.d_rs2_read;
    bus.rf_rs2_raddr  = bus.d_rs2_raddr;
    bus.rf_rs1_read   = grant ? 1'b1 : bus.d_rs1_read;
    bus.rf_rs1_raddr  = grant ? bus.dbg_rf_addr : bus.d_rs1_raddr;
    bus.d_stall       = grant && !port_free;
    bus.dbg_rf_ack    = grant;
    bus.dbg_rf_busy   = (state != IDLE);
    bus.dbg_rf_rvalid = rvalid_q;
    bus.dbg_rf_rdata  = rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 8'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state      <= RESP;
            starve_cnt <= 8'd0;
          end else if (bus.dbg_rf_req) begin
            state      <= WAIT;
            starve_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (grant) begin
            state      <= RESP;
            starve_cnt <= 8'd0;
          end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
          end
        end
        // Regfile data for the read issued last cycle is valid now.
        RESP: begin
          state    <= IDLE;
          rvalid_q <= 1'b1;
          rdata_q  <= bus.rf_rs1_rdata;
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
